// File: rtl/rnd_ser_pkg.sv
// Shared definitions for the random-word bit serializer.
// Holds the serializer state encoding and the default word / divider widths
// that the LFSR, the serializer and the top level agree on.
package rnd_ser_pkg;

    // Width of the random number bus produced by the LFSR.
    localparam int RND_WIDTH = 16;
    // Width of the bit-rate divider programmed by the host.
    localparam int RND_DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_e;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-rate tick generator for the serializer.
// A loadable down-counter: while run is high it produces a tick whenever the
// count is 0 and reloads with div, otherwise it counts down. clear forces the
// count to 0 so the first tick after a capture comes immediately.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : global enable, low freezes the counter
//   clear    : zero the counter (word capture)
//   run      : counting active (word in flight)
//   div      : reload value, one tick every div+1 enabled cycles
//   tick     : high while the count is 0 and run is high
module bit_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (clear) begin
                cnt_d = '0;
            end else if (run) begin
                cnt_d = (cnt_q == '0) ? div : (cnt_q - ONE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == '0);

endmodule

// File: rtl/rnd_bit_serializer.sv
// Random-word bit serializer between the LFSR and the cookie core.
// Captures one parallel word on start, then emits it one bit at a time with a
// one-cycle valid strobe every div+1 cycles, MSB or LSB first.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : global enable; low freezes all state and masks strobes
//   start      : capture load_word/div/msb_first and begin (IDLE only)
//   load_word  : parallel word to serialize
//   div        : inter-bit gap, one bit every div+1 cycles
//   msb_first  : 1 = MSB first, 0 = LSB first
//   ser_bit    : current serial bit, held between strobes
//   ser_valid  : one-cycle strobe qualifying ser_bit
//   busy       : word in flight (capture until last bit emitted)
//   done       : one-cycle pulse after the last bit
//   bits_sent  : bits emitted in the current or last word
module rnd_bit_serializer
    import rnd_ser_pkg::*;
#(
    parameter int WIDTH = RND_WIDTH,
    parameter int DIV_W = RND_DIV_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] load_word,
    input  logic [DIV_W-1:0] div,
    input  logic             msb_first,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bits_sent
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    ser_state_e       state_q,     state_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic             msb_q,       msb_d;
    logic             ser_bit_q,   ser_bit_d;
    logic             ser_valid_q, ser_valid_d;
    logic [CNT_W-1:0] bits_sent_q, bits_sent_d;

    logic tick;
    logic tick_clear;
    logic tick_run;

    // The tick counter only runs while bits remain; once the last bit is out
    // the FSM moves on without waiting for the divider.
    assign tick_clear = (state_q == IDLE) && start;
    assign tick_run   = (state_q == SHIFT) && (bits_sent_q != LAST_CNT);

    bit_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (tick_clear),
        .run   (tick_run),
        .div   (div_q),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        div_d       = div_q;
        msb_d       = msb_q;
        ser_bit_d   = ser_bit_q;
        ser_valid_d = ser_valid_q;
        bits_sent_d = bits_sent_q;

        // With en low nothing moves, so a registered strobe or the DONE state
        // survives until the next enabled cycle.
        if (en) begin
            case (state_q)
                IDLE: begin
                    ser_valid_d = 1'b0;
                    if (start) begin
                        shreg_d     = load_word;
                        div_d       = div;
                        msb_d       = msb_first;
                        bits_sent_d = '0;
                        state_d     = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bits_sent_q == LAST_CNT) begin
                        ser_valid_d = 1'b0;
                        state_d     = DONE;
                    end else if (tick) begin
                        ser_valid_d = 1'b1;
                        bits_sent_d = bits_sent_q + ONE_CNT;
                        if (msb_q) begin
                            ser_bit_d = shreg_q[WIDTH-1];
                            shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                        end else begin
                            ser_bit_d = shreg_q[0];
                            shreg_d   = {1'b0, shreg_q[WIDTH-1:1]};
                        end
                    end else begin
                        ser_valid_d = 1'b0;
                    end
                end
                DONE: begin
                    ser_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                default: begin
                    ser_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            div_q       <= '0;
            msb_q       <= 1'b0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            bits_sent_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            div_q       <= div_d;
            msb_q       <= msb_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            bits_sent_q <= bits_sent_d;
        end
    end

    // Strobe and done are masked while en is low; the held registers replay
    // them once en returns.
    assign ser_valid = ser_valid_q && en;
    assign done      = (state_q == DONE) && en;
    assign busy      = (state_q == SHIFT);
    assign ser_bit   = ser_bit_q;
    assign bits_sent = bits_sent_q;

endmodule

// File: tb/tb_rnd_bit_serializer.sv
module tb_rnd_bit_serializer;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [15:0] load_word;
    logic [7:0]  div;
    logic        msb_first;
    logic        ser_bit;
    logic        ser_valid;
    logic        busy;
    logic        done;
    logic [4:0]  bits_sent;

    rnd_bit_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .load_word (load_word),
        .div       (div),
        .msb_first (msb_first),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done),
        .bits_sent (bits_sent)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            if (errs <= 30)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] word;
        logic [7:0]  dv;
        logic        msb;
        int          gap_at;
        int          gap_len;
        logic [15:0] exp_seq;   // emission order, first bit in bit 15
        int          exp_done;  // cycle of the done pulse, capture edge = 0
    } vec_t;

    vec_t tbl[6];

    task automatic run_vec(input vec_t v);
        logic [15:0] seq;
        int nstb, done_cnt, done_at, space_bad, gap_stb;
        logic busy_at_done;
        logic [4:0] bits_at_done;
        seq = '0; nstb = 0; done_cnt = 0; done_at = -1; space_bad = 0; gap_stb = 0;
        busy_at_done = 1'b1; bits_at_done = '0;
        @(negedge clk);
        load_word = v.word; div = v.dv; msb_first = v.msb; start = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after capture: the word in flight must not change.
        start = 1'b0; load_word = ~v.word; div = 8'd7; msb_first = ~v.msb;
        for (int c = 1; c <= v.exp_done + 6; c++) begin
            @(posedge clk); #1;
            en    = !(v.gap_len > 0 && c >= v.gap_at && c < v.gap_at + v.gap_len);
            start = (c >= 2 && c <= 6);   // re-request while busy
            @(negedge clk);
            if (ser_valid) begin
                if (!en) gap_stb++;
                if (v.gap_len == 0 && c != 1 + nstb * (int'(v.dv) + 1)) space_bad++;
                seq = {seq[14:0], ser_bit};
                nstb++;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c; busy_at_done = busy; bits_at_done = bits_sent;
                end
            end
        end
        start = 1'b0; en = 1'b1;
        chk("bit_sequence", 32'(seq), 32'(v.exp_seq));
        chk("strobe_count", nstb, 16);
        chk("strobe_spacing_errors", space_bad, 0);
        chk("strobes_while_en_low", gap_stb, 0);
        chk("done_pulses", done_cnt, 1);
        chk("done_cycle", done_at, v.exp_done);
        chk("busy_at_done", 32'(busy_at_done), 0);
        chk("bits_sent_at_done", 32'(bits_at_done), 16);
        chk("bits_sent_held", 32'(bits_sent), 16);
        chk("busy_after", 32'(busy), 0);
    endtask

    // ---------------- behavioural reference model ----------------
    // A word captured at an enabled edge is described by m, the number of
    // enabled edges since capture: strobe i falls on m = 1 + i*(div+1),
    // done on the edge after the last strobe, idle one edge later.
    logic        m_act;
    int          m_m;
    int          m_d;
    logic [15:0] m_w;
    logic        m_msb;
    logic        m_bit;
    int          m_bits;

    function automatic int m_last();
        return 1 + (W - 1) * (m_d + 1);
    endfunction

    function automatic logic m_idle();
        return !m_act || (m_m >= m_last() + 2);
    endfunction

    task automatic model_reset();
        m_act = 1'b0; m_m = 0; m_d = 0; m_w = '0; m_msb = 1'b0; m_bit = 1'b0; m_bits = 0;
    endtask

    task automatic model_edge(input logic e, input logic s, input logic [15:0] w,
                              input logic [7:0] dv, input logic mf);
        int idx;
        if (!e) return;
        if (m_idle()) begin
            if (s) begin
                m_act = 1'b1; m_m = 0; m_d = int'(dv); m_w = w; m_msb = mf; m_bits = 0;
            end
        end else begin
            m_m++;
            if (m_m <= m_last() && ((m_m - 1) % (m_d + 1)) == 0) begin
                idx    = (m_m - 1) / (m_d + 1);
                m_bit  = m_msb ? m_w[W-1-idx] : m_w[idx];
                m_bits = idx + 1;
            end
        end
    endtask

    initial begin
        int nstb;
        logic exp_v, exp_d, exp_b;

        tbl[0] = '{16'hA5C3, 8'd0, 1'b1, 0, 0, 16'hA5C3, 17};
        tbl[1] = '{16'h0001, 8'd2, 1'b0, 0, 0, 16'h8000, 47};
        tbl[2] = '{16'hF00D, 8'd1, 1'b1, 0, 0, 16'hF00D, 32};
        tbl[3] = '{16'h1234, 8'd0, 1'b0, 0, 0, 16'h2C48, 17};
        tbl[4] = '{16'hA5C3, 8'd0, 1'b1, 5, 5, 16'hA5C3, 22};
        tbl[5] = '{16'h8421, 8'd3, 1'b1, 0, 0, 16'h8421, 62};

        rst = 1'b1; en = 1'b0; start = 1'b0; load_word = '0; div = '0; msb_first = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("reset_ser_valid", 32'(ser_valid), 0);
        chk("reset_busy",      32'(busy), 0);
        chk("reset_done",      32'(done), 0);
        chk("reset_bits_sent", 32'(bits_sent), 0);
        chk("reset_ser_bit",   32'(ser_bit), 0);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Asynchronous reset while idle with held outputs (bits_sent=16,
        // last bit of 0x8421 MSB-first is 1).
        @(negedge clk); #2;
        rst = 1'b1; #1;
        chk("idle_rst_bits_sent", 32'(bits_sent), 0);
        chk("idle_rst_ser_bit",   32'(ser_bit), 0);
        chk("idle_rst_busy",      32'(busy), 0);
        @(negedge clk); rst = 1'b0;

        // Reset after the 7th strobe aborts the word without done.
        @(negedge clk);
        load_word = 16'hFFFF; div = 8'd0; msb_first = 1'b1; start = 1'b1; en = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        nstb = 0;
        for (int c = 0; c < 40 && nstb < 7; c++) begin
            @(negedge clk);
            if (ser_valid) nstb++;
        end
        chk("strobes_before_abort", nstb, 7);
        #2; rst = 1'b1; #1;
        chk("abort_ser_valid", 32'(ser_valid), 0);
        chk("abort_busy",      32'(busy), 0);
        chk("abort_bits_sent", 32'(bits_sent), 0);
        @(negedge clk); rst = 1'b0;
        nstb = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done || ser_valid || busy) nstb++;
        end
        chk("activity_after_abort", nstb, 0);
        run_vec(tbl[3]);

        // Randomized run against the reference model.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            model_edge(en, start, load_word, div, msb_first);
            #1;
            en        = ($urandom_range(0, 9) != 0);
            start     = ($urandom_range(0, 3) == 0);
            load_word = 16'($urandom);
            div       = 8'($urandom_range(0, 4));
            msb_first = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_b = m_act && (m_m <= m_last());
            exp_v = m_act && m_m >= 1 && m_m <= m_last() && ((m_m - 1) % (m_d + 1)) == 0 && en;
            exp_d = m_act && (m_m == m_last() + 1) && en;
            chk("rand_ser_valid", 32'(ser_valid), 32'(exp_v));
            chk("rand_done",      32'(done), 32'(exp_d));
            chk("rand_busy",      32'(busy), 32'(exp_b));
            chk("rand_bits_sent", 32'(bits_sent), 32'(m_bits));
            chk("rand_ser_bit",   32'(ser_bit), 32'(m_bit));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule

// File: doc/rnd_bit_serializer.md
Name: rnd_bit_serializer

Overview:
- Sits between the LFSR random-number generator and the cookie core.
- Captures one parallel random word on request and shifts it out one bit at a time on the cookie core's serial input.
- Each bit is accompanied by a one-cycle run strobe, at a programmable bit rate.
- Reports busy/done so the top level or a host can sequence successive words.

Parameters:
WIDTH, 16, bits per captured word (matches the 16-bit random number bus)
DIV_W, 8, width of the bit-rate divider input
CNT_W, $clog2(WIDTH+1), width of the bits_sent counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  global enable; low freezes all state
start  input  1  request to capture load_word and begin shifting
load_word  input  WIDTH  parallel word to serialize (random number bus)
div  input  DIV_W  inter-bit gap; one bit every div+1 cycles
msb_first  input  1  1 = shift MSB first, 0 = LSB first
ser_bit  output  1  current serial bit (drives cookie input_bit)
ser_valid  output  1  one-cycle strobe marking ser_bit valid (drives cookie run)
busy  output  1  high from capture until the final bit has been emitted
done  output  1  one-cycle pulse after the final bit
bits_sent  output  CNT_W  number of bits emitted in the current or last word

Behaviour:
- Reset (asynchronous, active-high): all outputs, state and counters go to 0; state = IDLE. Reset asserted mid-word aborts the word with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on a clock edge where en=1 and start=1:
  - load_word, div and msb_first are captured into internal registers.
  - bits_sent <= 0; busy <= 1; tick counter <= 0.
  - Inputs changing after capture have no effect on the word in flight.
- In SHIFT, when the tick counter is 0:
  - emit the next bit: ser_bit <= shreg MSB (or LSB); ser_valid <= 1.
  - shift the register; bits_sent++; reload the tick counter with captured div.
- Otherwise decrement the tick counter with ser_valid <= 0.
- Timing: start sampled at edge k -> first ser_valid visible in cycle k+1, then every div+1 cycles. div=0 gives back-to-back bits.
- After the WIDTH-th bit's strobe cycle: state = DONE for exactly one cycle (done=1, busy=0, ser_valid=0), then IDLE.
- ser_bit holds its last value between strobes and after completion. bits_sent holds WIDTH until the next capture.
- start while busy or in DONE is ignored; no queuing. start must be re-asserted in IDLE.
- en=0: every register holds and ser_valid/done are forced 0 that cycle.
  - A pending strobe or done is deferred, not lost; it fires on the first cycle with en=1.
  - start is ignored while en=0.
- start and rst together: rst wins.

Decomposition:
- Shared package rnd_ser_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - default WIDTH/DIV_W constants shared with the LFSR and top level.
- One sub-module, bit_tick_gen:
  - loadable down-counter with en gating;
  - produces the tick when it reaches 0 and reloads with div.
- The shift register, bit counter and FSM stay in the parent.

Test Plan:
- Reset during idle:
  - rst pulse mid-cycle (asynchronous) -> all outputs 0 immediately, state IDLE.
- div=0, MSB first, word 0xA5C3, start at edge 0:
  - ser_valid high cycles 1..16;
  - ser_bit sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1;
  - done=1 in cycle 17, bits_sent=16.
- div=2, LSB first, word 0x0001:
  - strobes at cycles 1,4,7,...,46; first bit 1, remaining 0;
  - done in cycle 47; busy low from 47.
- start re-asserted while busy with a different word -> ignored; original word's bits unchanged; exactly one done.
- en dropped for 5 cycles mid-word (div=0) -> no strobes during the gap; the bit sequence resumes intact; done is delayed by exactly 5 cycles.
- rst asserted after the 7th strobe -> ser_valid, busy and bits_sent go to 0; no done pulse; next start serializes a fresh word from bit 0.
